// File: rtl/ws2811_frame_sequencer.sv
// WS2811 frame sequencer: streams bytes from a valid/ready source as fixed-width bit cells
// and closes each frame with a latch low period. States: IDLE | PRIME | CELL | STALL | LATCH.
module ws2811_frame_sequencer #(
  parameter int CELL_CYC      = 75,
  parameter int T0H_CYC       = 19,
  parameter int T1H_CYC       = 56,
  parameter int LATCH_CYC     = 3000,
  parameter int STALL_MAX_CYC = 1500,
  parameter int NUM_LEDS      = 50
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       ws2811,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  // state | meaning
  // IDLE  | line low, waiting for start
  // PRIME | waiting for the first byte of the frame
  // CELL  | emitting bit cells from sh
  // STALL | byte boundary reached with hold empty, line low
  // LATCH | closing low period
  typedef enum logic [2:0] {S_IDLE, S_PRIME, S_CELL, S_STALL, S_LATCH} state_t;

  localparam int NBYTES = 3 * NUM_LEDS;
  localparam int BW     = $clog2(NBYTES + 1);
  localparam int CW     = (CELL_CYC > 1) ? $clog2(CELL_CYC) : 1;
  localparam int TMAX   = (LATCH_CYC > STALL_MAX_CYC) ? LATCH_CYC : STALL_MAX_CYC;
  localparam int TW     = $clog2(TMAX + 1);

  localparam logic [BW-1:0] BYTES_ALL  = BW'(NBYTES);
  localparam logic [CW-1:0] CELL_LAST  = CW'(CELL_CYC - 1);
  localparam logic [CW-1:0] T0H_W      = CW'(T0H_CYC);
  localparam logic [CW-1:0] T1H_W      = CW'(T1H_CYC);
  localparam logic [TW-1:0] LATCH_LAST = TW'(LATCH_CYC - 1);
  localparam logic [TW-1:0] STALL_LAST = TW'(STALL_MAX_CYC - 1);

  state_t        state, state_nx;
  logic [7:0]    sh, sh_nx, hold, hold_nx;
  logic [2:0]    bitcnt, bitcnt_nx;
  logic          hold_full, hold_full_nx;
  logic [BW-1:0] bytecnt, bytecnt_nx;
  logic [CW-1:0] cellcnt, cellcnt_nx;
  logic [TW-1:0] tcnt, tcnt_nx;
  logic          underrun_nx, frame_done_nx;
  logic          accept, boundary;

  assign busy     = (state != S_IDLE);
  assign in_ready = busy && (state != S_LATCH) && !hold_full && (bytecnt < BYTES_ALL);
  assign accept   = in_ready && in_valid;
  assign boundary = (cellcnt == CELL_LAST) && (bitcnt == 3'd7);
  // Gated by rst_ so the line drops the moment reset is asserted.
  assign ws2811   = rst_ && (state == S_CELL) && (cellcnt < (sh[7] ? T1H_W : T0H_W));

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state      <= S_IDLE;
      sh         <= '0;
      hold       <= '0;
      bitcnt     <= '0;
      hold_full  <= 1'b0;
      bytecnt    <= '0;
      cellcnt    <= '0;
      tcnt       <= '0;
      underrun   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      sh         <= sh_nx;
      hold       <= hold_nx;
      bitcnt     <= bitcnt_nx;
      hold_full  <= hold_full_nx;
      bytecnt    <= bytecnt_nx;
      cellcnt    <= cellcnt_nx;
      tcnt       <= tcnt_nx;
      underrun   <= underrun_nx;
      frame_done <= frame_done_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    sh_nx         = sh;
    hold_nx       = hold;
    bitcnt_nx     = bitcnt;
    hold_full_nx  = hold_full;
    bytecnt_nx    = accept ? bytecnt + BW'(1) : bytecnt;
    cellcnt_nx    = cellcnt;
    tcnt_nx       = tcnt;
    underrun_nx   = underrun;
    frame_done_nx = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx     = S_PRIME;
          underrun_nx  = 1'b0;
          bytecnt_nx   = '0;
          cellcnt_nx   = '0;
          tcnt_nx      = '0;
          bitcnt_nx    = '0;
          hold_full_nx = 1'b0;
        end
      end
      S_PRIME: begin
        if (accept) begin
          sh_nx      = in_data;
          bitcnt_nx  = '0;
          cellcnt_nx = '0;
          state_nx   = S_CELL;
        end
      end
      S_CELL: begin
        if (cellcnt != CELL_LAST) begin
          cellcnt_nx = cellcnt + CW'(1);
        end else begin
          cellcnt_nx = '0;
          if (bitcnt != 3'd7) begin
            sh_nx     = {sh[6:0], 1'b0};
            bitcnt_nx = bitcnt + 3'd1;
          end else begin
            bitcnt_nx = '0;
            // A byte arriving on the boundary cycle goes straight into sh.
            if (hold_full) begin
              sh_nx        = hold;
              hold_full_nx = 1'b0;
            end else if (accept) begin
              sh_nx = in_data;
            end else if (bytecnt == BYTES_ALL) begin
              state_nx = S_LATCH;
              tcnt_nx  = '0;
            end else begin
              state_nx = S_STALL;
              tcnt_nx  = '0;
            end
          end
        end
        if (accept && !boundary) begin
          hold_nx      = in_data;
          hold_full_nx = 1'b1;
        end
      end
      S_STALL: begin
        if (accept) begin
          sh_nx      = in_data;
          bitcnt_nx  = '0;
          cellcnt_nx = '0;
          state_nx   = S_CELL;
        end else if (tcnt == STALL_LAST) begin
          underrun_nx = 1'b1;
          state_nx    = S_LATCH;
          tcnt_nx     = '0;
        end else begin
          tcnt_nx = tcnt + TW'(1);
        end
      end
      S_LATCH: begin
        if (tcnt == LATCH_LAST) begin
          state_nx      = S_IDLE;
          frame_done_nx = 1'b1;
          tcnt_nx       = '0;
        end else begin
          tcnt_nx = tcnt + TW'(1);
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ws2811_frame_sequencer.sv
// Bench for ws2811_frame_sequencer with small timing parameters; a frame-level timing model
// predicts handshake cycles, the line waveform, frame length and underrun.
module tb_ws2811_frame_sequencer;
  localparam int CELL = 8, T0H = 2, T1H = 6, LATCH = 20, STALL = 10, NL = 1;
  localparam int NB = 3 * NL;
  localparam int MAXREL = 1000;

  logic       clk = 1'b0;
  logic       rst_, start, in_valid;
  logic [7:0] in_data;
  logic       in_ready, ws2811, busy, frame_done, underrun;

  always #5 clk = ~clk;

  ws2811_frame_sequencer #(
    .CELL_CYC(CELL), .T0H_CYC(T0H), .T1H_CYC(T1H),
    .LATCH_CYC(LATCH), .STALL_MAX_CYC(STALL), .NUM_LEDS(NL)
  ) dut (
    .clk(clk), .rst_(rst_), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .ws2811(ws2811), .busy(busy), .frame_done(frame_done),
    .underrun(underrun)
  );

  int checks = 0;
  int errors = 0;
  bit und_now = 1'b0;

  bit exp_line [MAXREL];
  int exp_hs [NB];
  int exp_nhs, exp_len;
  bit exp_und;

  typedef struct {
    logic [23:0] bytes;
    int d0, d1, d2, st1, st2, len;
    bit und;
    int hs;
  } vec_t;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Byte k is offered d[k] cycles after the previous handshake (byte 0: after start).
  // It is taken once hold is free, i.e. when the previous byte starts on the line.
  task automatic model_frame(input logic [23:0] bytes, input int d0, input int d1, input int d2);
    int d [3];
    int h_prev, ready_from, s, e_prev, h, v, latch_start;
    bit ab;
    logic [7:0] bv;
    d[0] = d0; d[1] = d1; d[2] = d2;
    h_prev = 0; ready_from = 1; e_prev = 0; s = 0; ab = 1'b0;
    for (int i = 0; i < MAXREL; i++) exp_line[i] = 1'b0;
    exp_nhs = 0;
    for (int k = 0; k < NB; k++) begin
      v = h_prev + 1 + d[k];
      h = (v > ready_from) ? v : ready_from;
      if (k == 0) s = h + 1;
      else if (h <= e_prev) s = e_prev + 1;
      else if (h <= e_prev + STALL) s = h + 1;
      else begin
        ab = 1'b1;
        break;
      end
      exp_hs[k] = h;
      exp_nhs++;
      bv = bytes[8*k +: 8];
      for (int i = 0; i < 8; i++)
        for (int t = 0; t < CELL; t++)
          exp_line[s + i*CELL + t] = (t < (bv[7-i] ? T1H : T0H));
      e_prev = s + 8*CELL - 1;
      ready_from = s;
      h_prev = h;
    end
    latch_start = ab ? e_prev + STALL + 1 : e_prev + 1;
    exp_len = latch_start + LATCH;
    exp_und = ab;
  endtask

  task automatic run_frame(input string tag, input logic [23:0] bytes,
                           input int d0, input int d1, input int d2,
                           input int st1, input int st2, input int rst_at,
                           input bit use_model, input int t_len, input bit t_und, input int t_hs);
    int dd [3];
    int k, last_h, len, nhs, terr, el, eh, extra;
    bit hs_bad, und_d, busy_d, und0, und1, eu;
    dd[0] = d0; dd[1] = d1; dd[2] = d2;
    k = 0; last_h = 0; len = -1; nhs = 0; terr = 0; extra = 0;
    hs_bad = 0; und_d = 0; busy_d = 1; und0 = 0; und1 = 1;
    model_frame(bytes, d0, d1, d2);
    el = use_model ? exp_len : t_len;
    eu = use_model ? exp_und : t_und;
    eh = use_model ? exp_nhs : t_hs;
    for (int rel = 0; rel < MAXREL; rel++) begin
      if (ws2811 !== exp_line[rel]) terr++;
      if (rel == 0) und0 = underrun;
      if (rel == 1) und1 = underrun;
      if (frame_done) begin
        len = rel;
        und_d = underrun;
        busy_d = busy;
        break;
      end
      start = (rel == 0) || (st1 > 0 && rel == st1) || (st2 > 0 && rel == st2);
      in_valid = (k < NB) && (rel >= last_h + 1 + dd[k]);
      if (in_valid) in_data = bytes[8*k +: 8];
      else in_data = 8'($urandom);
      if (in_valid && in_ready) begin
        if (nhs >= exp_nhs || rel != exp_hs[nhs]) hs_bad = 1'b1;
        nhs++;
        k++;
        last_h = rel;
      end
      if (rst_at > 0 && rel == rst_at) rst_ = 1'b0;
      step();
      if (rst_at > 0 && rel == rst_at) begin
        check({tag, "/rst_ws2811"}, int'(ws2811), 0);
        check({tag, "/rst_busy"}, int'(busy), 0);
        check({tag, "/rst_in_ready"}, int'(in_ready), 0);
        check({tag, "/trace_before_rst"}, terr, 0);
        rst_ = 1'b1; start = 1'b0; in_valid = 1'b0;
        und_now = 1'b0;
        step();
        return;
      end
    end
    start = 1'b0;
    in_valid = 1'b0;
    check({tag, "/underrun_sticky"}, int'(und0), int'(und_now));
    check({tag, "/underrun_cleared"}, int'(und1), 0);
    check({tag, "/frame_len"}, len, el);
    check({tag, "/line_trace_errs"}, terr, 0);
    check({tag, "/underrun"}, int'(und_d), int'(eu));
    check({tag, "/busy_at_done"}, int'(busy_d), 0);
    check({tag, "/handshakes"}, nhs, eh);
    check({tag, "/hs_timing"}, int'(hs_bad), 0);
    repeat (5) begin
      step();
      if (frame_done || busy) extra++;
    end
    check({tag, "/idle_after"}, extra, 0);
    und_now = eu;
  endtask

  vec_t tbl [7];

  initial begin
    int act;
    int r;
    logic [23:0] rb;
    int rd [3];

    tbl[0] = '{24'hFF00A5,  0,  0,   0,  0,   0, 214, 1'b0, 3};
    tbl[1] = '{24'hFF00A5,  0, 68,   0,  0,   0, 219, 1'b0, 3};
    tbl[2] = '{24'hFF00A5,  0,  0, 142,  0,   0, 160, 1'b1, 2};
    tbl[3] = '{24'h0FF033,  0, 73,   0,  0,   0, 224, 1'b0, 3};
    tbl[4] = '{24'h0FF033,  0, 74,   0,  0,   0,  96, 1'b1, 1};
    tbl[5] = '{24'h5AC3E1,  0, 63,   0,  0,   0, 214, 1'b0, 3};
    tbl[6] = '{24'h81C33C, 30,  0,   0, 40, 235, 244, 1'b0, 3};

    rst_ = 1'b0; start = 1'b1; in_valid = 1'b1; in_data = 8'h5A;
    repeat (3) step();
    check("reset_ws2811", int'(ws2811), 0);
    check("reset_in_ready", int'(in_ready), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_frame_done", int'(frame_done), 0);
    check("reset_underrun", int'(underrun), 0);
    rst_ = 1'b1; start = 1'b0;
    act = 0;
    repeat (20) begin
      step();
      if (busy || in_ready || ws2811) act++;
    end
    check("no_frame_without_start", act, 0);
    in_valid = 1'b0;

    for (int i = 0; i < 7; i++)
      run_frame($sformatf("row%0d", i), tbl[i].bytes, tbl[i].d0, tbl[i].d1, tbl[i].d2,
                tbl[i].st1, tbl[i].st2, 0, 1'b0, tbl[i].len, tbl[i].und, tbl[i].hs);

    run_frame("midrst", 24'hFF00A5, 0, 0, 0, 0, 0, 100, 1'b1, 0, 1'b0, 0);
    run_frame("after_rst", tbl[0].bytes, 0, 0, 0, 0, 0, 0, 1'b0, tbl[0].len, tbl[0].und, tbl[0].hs);

    for (int n = 0; n < 12; n++) begin
      rb = 24'($urandom);
      rd[0] = $urandom_range(0, 20);
      for (int k = 1; k < 3; k++) begin
        r = $urandom_range(0, 9);
        if (r < 6) rd[k] = $urandom_range(0, 10);
        else if (r < 9) rd[k] = $urandom_range(55, 75);
        else rd[k] = $urandom_range(76, 110);
      end
      run_frame($sformatf("rand%0d", n), rb, rd[0], rd[1], rd[2], 0, 0, 0, 1'b1, 0, 1'b0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
